mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum BUSY cycles without bus_ack_i before the access is aborted.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_valid_i  input  1  load/store present in MEM stage this cycle.
REQ-005 mem_we_i  input  1  1 = store, 0 = load.
REQ-006 funct3_i  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 addr_i  input  32  byte address (EX result).
REQ-008 wdata_i  input  32  store data (rs2 value).
REQ-009 stall_o  output  1  freeze IF..EX/MEM pipeline registers.
REQ-010 bus_req_o  output  1  data-bus request.
REQ-011 bus_we_o  output  1  bus write enable.
REQ-012 bus_addr_o  output  32  word address, bits [1:0] forced to 00.
REQ-013 bus_be_o  output  4  byte enables.
REQ-014 bus_wdata_o  output  32  lane-aligned store data.
REQ-015 bus_ack_i  input  1  bus completion; rdata valid in the same cycle.
REQ-016 bus_rdata_i  input  32  read word.
REQ-017 load_data_o  output  32  extended load result, toward MEM/WB.
REQ-018 load_valid_o  output  1  one-cycle pulse, load_data_o updated.
REQ-019 err_o  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout.

Function
REQ-020 FSM states IDLE, BUSY, DONE; encoded as a 2-bit enum.
REQ-021 Legal access: funct3 in {000,001,010,100,101}; aligned: H/HU addr_i[0]=0, W addr_i[1:0]=00.
REQ-022 IDLE, mem_valid_i=1, legal and aligned: next state BUSY; bus_* fields registered from inputs at that edge.
REQ-023 IDLE, mem_valid_i=1, illegal or misaligned: no bus request, err_o pulses next cycle, next state DONE.
REQ-024 bus_req_o = 1 exactly while in BUSY; bus_addr_o/be/wdata/we are stable throughout BUSY.
REQ-025 Byte enables: B/BU 0001<<addr[1:0]; H/HU 0011<<{addr[1],0}; W 1111.
REQ-026 bus_wdata_o: B lanes hold wdata[7:0] replicated x4; H lanes hold wdata[15:0] replicated x2; W lanes hold wdata unchanged.
REQ-027 BUSY, bus_ack_i=1: next state DONE; for a load, capture the selected lane of bus_rdata_i, sign/zero-extend per funct3 into load_data_o, and pulse load_valid_o in the DONE cycle.
REQ-028 BUSY, no ack: the wait counter increments; when it reaches TIMEOUT, next state DONE, err_o pulses, and load_data_o is left unchanged.
REQ-029 stall_o = (IDLE & mem_valid_i & legal & aligned) | BUSY; combinational.
REQ-030 DONE lasts exactly one cycle with stall_o=0, letting the pipeline advance; DONE -> IDLE unconditionally and mem_valid_i is ignored in DONE, so no re-issue occurs.
REQ-031 A bus_ack_i arriving outside BUSY is ignored.
REQ-032 An ack in the same cycle as the counter reaching TIMEOUT is treated as success: no err_o.
REQ-033 Stores produce no load_valid_o pulse; load latency is 1 issue cycle + N wait cycles + 1 DONE cycle.

Reset
REQ-034 rst asserted: state IDLE; wait counter 0; bus_req_o, bus_we_o, load_valid_o and err_o all 0; bus_addr_o, bus_be_o, bus_wdata_o and load_data_o all 0.
REQ-035 rst during BUSY abandons the access immediately: bus_req_o drops asynchronously, with no err_o or load_valid_o pulse.

Structure
REQ-036 Package mem_pkg holds the funct3 constants, the FSM state enum and the lane-mask constants.
REQ-037 One combinational sub-module, mem_lane_align, generates byte enables, store replication and load extraction/extension.

Verification
REQ-038 LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, stall for 3 cycles, load_data 0xDEADBEEF.
REQ-039 LB addr 0x103, rdata 0x80FF_FF_FF -> be 1000, load_data 0xFFFFFF80; LBU on the same access -> 0x00000080.
REQ-040 SH addr 0x202, wdata 0x1234ABCD -> be 1100, bus_wdata 0xABCDABCD, bus_we 1, no load_valid.
REQ-041 LW addr 0x101 -> no bus_req, err_o pulse, stall_o stays 0.
REQ-042 LW with ack withheld -> after 16 BUSY cycles err_o pulses, bus_req drops, load_data unchanged.
REQ-043 rst asserted in the 2nd BUSY cycle -> bus_req 0 immediately; after release, state IDLE and a fresh LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage load/store unit: funct3 codes, FSM states,
// byte-lane masks and the legality/alignment test.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal funct3 and naturally aligned for its size.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: access_ok = 1'b1;
      F3_H, F3_HU: access_ok = ~off[0];
      F3_W:        access_ok = (off == 2'b00);
      default:     access_ok = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the load/store unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and store replication for an issue,
// lane extraction and sign/zero extension for a returning load word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] ldata
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    be     = '0;
    wlanes = wdata;
    ldata  = '0;
    case (funct3)
      F3_B: begin
        be     = BE_B << off;
        wlanes = {4{wdata[7:0]}};
        ldata  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        be     = BE_B << off;
        wlanes = {4{wdata[7:0]}};
        ldata  = {24'b0, byte_sel};
      end
      F3_H: begin
        be     = BE_H << {off[1], 1'b0};
        wlanes = {2{wdata[15:0]}};
        ldata  = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        be     = BE_H << {off[1], 1'b0};
        wlanes = {2{wdata[15:0]}};
        ldata  = {16'b0, half_sel};
      end
      F3_W: begin
        be    = BE_W;
        ldata = rdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one bus access per instruction, stalls the
// pipeline until ack or timeout, then spends one DONE cycle releasing it.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_valid_i,
  input  logic                mem_we_i,
  input  logic [2:0]          funct3_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic                stall_o,
  mem_access_unit_if.master   bus,
  output logic [31:0]         load_data_o,
  output logic                load_valid_o,
  output logic                err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          ok, issue, reject, ack, tmo;
  logic [2:0]    al_f3;
  logic [1:0]    al_off;
  logic [3:0]    al_be;
  logic [31:0]   al_wlanes, al_ldata;

  assign ok     = access_ok(funct3_i, addr_i[1:0]);
  assign issue  = (state == IDLE) & mem_valid_i & ok;
  assign reject = (state == IDLE) & mem_valid_i & ~ok;
  assign ack    = (state == BUSY) & bus.bus_ack_i;
  // Ack wins over an expiring counter in the same cycle.
  assign tmo    = (state == BUSY) & ~bus.bus_ack_i & (cnt == CW'(TIMEOUT - 1));

  // One aligner serves both directions: issue fields in IDLE, captured fields in BUSY.
  assign al_f3  = (state == IDLE) ? funct3_i    : f3_q;
  assign al_off = (state == IDLE) ? addr_i[1:0] : off_q;

  mem_lane_align u_align (
    .funct3 (al_f3),
    .off    (al_off),
    .wdata  (wdata_i),
    .rdata  (bus.bus_rdata_i),
    .be     (al_be),
    .wlanes (al_wlanes),
    .ldata  (al_ldata)
  );

  always_comb begin
    state_nx      = state;
    stall_o       = issue | (state == BUSY);
    bus.bus_req_o = (state == BUSY);
    case (state)
      IDLE:    if (mem_valid_i) state_nx = ok ? BUSY : DONE;
      BUSY:    if (ack | tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      f3_q            <= '0;
      off_q           <= '0;
      bus.bus_we_o    <= 1'b0;
      bus.bus_addr_o  <= '0;
      bus.bus_be_o    <= '0;
      bus.bus_wdata_o <= '0;
      load_data_o     <= '0;
      load_valid_o    <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state        <= state_nx;
      load_valid_o <= 1'b0;
      err_o        <= 1'b0;
      if (issue) begin
        bus.bus_addr_o  <= {addr_i[31:2], 2'b00};
        bus.bus_be_o    <= al_be;
        bus.bus_wdata_o <= al_wlanes;
        bus.bus_we_o    <= mem_we_i;
        f3_q            <= funct3_i;
        off_q           <= addr_i[1:0];
        cnt             <= '0;
      end
      if (reject) err_o <= 1'b1;
      if (state == BUSY) begin
        if (ack) begin
          if (!bus.bus_we_o) begin
            load_data_o  <= al_ldata;
            load_valid_o <= 1'b1;
          end
        end else if (tmo) begin
          err_o <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
